change_dispenser: RTL

Downstream stage of the coin machine. When the coin machine signals a vend with balance (`dispenseBalance`), this block takes its 8-bit credit `count` in cents and pays the balance back as change. It drives a three-tube coin hopper through a per-coin valid/ack handshake, using a greedy quarter → dime → nickel order with empty-tube fallback. It reports completion, undispensable residue, and hopper faults.

---
 rtl/coin_pkg.sv | 40 ++++
 rtl/change_dispenser_coin_select.sv | 33 +++
 rtl/change_dispenser.sv | 134 +++++++++++++
 3 files changed

// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : coin_pkg
//  Description : Shared coin values, dispenser state encoding and coin enum,
//                used by the change dispenser and the coin machine.
//  Revision    : 1.0 - initial release
// ============================================================================
package coin_pkg;

    // Coin values in cents
    localparam logic [7:0] NICKEL  = 8'd5;
    localparam logic [7:0] DIME    = 8'd10;
    localparam logic [7:0] QUARTER = 8'd25;

    // Change-dispenser state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_EJECT  = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_NICKEL  = 2'd1,
        COIN_DIME    = 2'd2,
        COIN_QUARTER = 2'd3
    } coin_e;

    // Value in cents of a coin selection (0 for no coin)
    function automatic logic [7:0] coin_value(input coin_e c);
        case (c)
            COIN_NICKEL:  coin_value = NICKEL;
            COIN_DIME:    coin_value = DIME;
            COIN_QUARTER: coin_value = QUARTER;
            default:      coin_value = 8'd0;
        endcase
    endfunction

endpackage : coin_pkg
`default_nettype wire

// File: rtl/change_dispenser_coin_select.sv
`default_nettype none
// ============================================================================
//  Module      : coin_select
//  Description : Combinational greedy coin picker. Chooses the largest coin
//                that fits the remaining balance and whose tube is not empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_select
    import coin_pkg::*;
(
    input  logic [7:0] remaining_i,
    input  logic       quarter_empty_i,
    input  logic       dime_empty_i,
    input  logic       nickel_empty_i,
    output coin_e      coin_o,
    output logic [7:0] value_o
);

    // Greedy quarter -> dime -> nickel, skipping empty tubes
    always_comb begin
        coin_o = COIN_NONE;
        if ((remaining_i >= QUARTER) && !quarter_empty_i) begin
            coin_o = COIN_QUARTER;
        end else if ((remaining_i >= DIME) && !dime_empty_i) begin
            coin_o = COIN_DIME;
        end else if ((remaining_i >= NICKEL) && !nickel_empty_i) begin
            coin_o = COIN_NICKEL;
        end
        value_o = coin_value(coin_o);
    end

endmodule : coin_select
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
//  Module      : change_dispenser
//  Description : Pays a credit balance back as change through a three-tube
//                hopper using a per-coin eject/ack handshake. Reports
//                completion, unpaid residue and sticky hopper timeout faults.
//  Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser
    import coin_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       dispenseBalance,
    input  logic [7:0] count,
    input  logic       quarterEmpty,
    input  logic       dimeEmpty,
    input  logic       nickelEmpty,
    input  logic       hopperAck,
    output logic       ejectQuarter,
    output logic       ejectDime,
    output logic       ejectNickel,
    output logic       busy,
    output logic       done,
    output logic [7:0] residue,
    output logic       fault
);

    // Last counter value before the request is declared lost
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [2:0] state_q,     state_d;
    logic [7:0] remaining_q, remaining_d;
    logic [7:0] residue_q,   residue_d;
    logic [7:0] value_q,     value_d;
    logic [7:0] tmo_q,       tmo_d;
    coin_e      coin_q,      coin_d;

    coin_e      pick_coin;
    logic [7:0] pick_value;

    coin_select u_coin_select (
        .remaining_i     (remaining_q),
        .quarter_empty_i (quarterEmpty),
        .dime_empty_i    (dimeEmpty),
        .nickel_empty_i  (nickelEmpty),
        .coin_o          (pick_coin),
        .value_o         (pick_value)
    );

    // Next-state logic for the FSM, balance, coin latch and timeout counter
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        residue_d   = residue_q;
        value_d     = value_q;
        tmo_d       = tmo_q;
        coin_d      = coin_q;
        case (state_q)
            ST_IDLE: begin
                if (dispenseBalance) begin
                    remaining_d = count;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (pick_coin == COIN_NONE) begin
                    // Residue is captured here so it is valid during the done pulse
                    residue_d = remaining_q;
                    state_d   = ST_DONE;
                end else begin
                    coin_d  = pick_coin;
                    value_d = pick_value;
                    tmo_d   = 8'd0;
                    state_d = ST_EJECT;
                end
            end
            ST_EJECT: begin
                // Ack wins over a timeout expiring in the same cycle
                if (hopperAck) begin
                    remaining_d = remaining_q - value_q;
                    state_d     = ST_SELECT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= 8'd0;
            residue_q   <= 8'd0;
            value_q     <= 8'd0;
            tmo_q       <= 8'd0;
            coin_q      <= COIN_NONE;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            residue_q   <= residue_d;
            value_q     <= value_d;
            tmo_q       <= tmo_d;
            coin_q      <= coin_d;
        end
    end

    // Outputs decoded from the registered state; FAULT forces all ejects low
    always_comb begin
        ejectQuarter = (state_q == ST_EJECT) && (coin_q == COIN_QUARTER);
        ejectDime    = (state_q == ST_EJECT) && (coin_q == COIN_DIME);
        ejectNickel  = (state_q == ST_EJECT) && (coin_q == COIN_NICKEL);
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        fault        = (state_q == ST_FAULT);
        residue      = residue_q;
    end

endmodule : change_dispenser
`default_nettype wire
